// File: rtl/tensor_core_engine.sv
// DIM x DIM signed tensor core: matmul, matmul-accumulate, add and ReLU,
// writing LANES saturated elements of the registered result matrix per cycle.

module tensor_core_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3,
  parameter int ACC_WIDTH  = 18,
  parameter int IDX_W      = 5,
  parameter int RC_W       = 2
) (
  input  logic [1:0]                              op,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] a,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] b,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] c_old,
  input  logic [IDX_W-1:0]                        elem,
  output logic                                    active,
  output logic [RC_W-1:0]                         row,
  output logic [RC_W-1:0]                         col,
  output logic [DATA_WIDTH-1:0]                   result
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = 2*DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [IDX_W-1:0] NELEM = IDX_W'(DIM*DIM);
  localparam logic [IDX_W-1:0] DIMI  = IDX_W'(DIM);
  localparam logic signed [SW-1:0] SMAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [PW-1:0]        ae, be;
  logic signed [ACC_WIDTH-1:0] dot;
  logic signed [W:0]           sum_add;
  logic signed [SW-1:0]        pre;
  logic [W-1:0]                a_e, b_e, c_e;

  always_comb begin
    active = elem < NELEM;
    row    = '0;
    col    = '0;
    // Inactive tail lanes park on element 0 so no index goes out of range.
    if (active) begin
      row = RC_W'(elem / DIMI);
      col = RC_W'(elem % DIMI);
    end
    a_e = a[row][col];
    b_e = b[row][col];
    c_e = c_old[row][col];
    ae  = '0;
    be  = '0;
    dot = '0;
    for (int k = 0; k < DIM; k++) begin
      ae  = PW'($signed(a[row][RC_W'(k)]));
      be  = PW'($signed(b[RC_W'(k)][col]));
      dot = dot + ACC_WIDTH'(ae * be);
    end
    sum_add = (W+1)'($signed(a_e)) + (W+1)'($signed(b_e));
    case (op)
      2'b00:   pre = SW'(dot);
      2'b11:   pre = SW'($signed(c_e)) + SW'(dot);
      2'b01:   pre = SW'(sum_add);
      default: pre = a_e[W-1] ? '0 : SW'($signed(a_e));
    endcase
    if (pre > SMAX)      result = SMAX[W-1:0];
    else if (pre < SMIN) result = SMIN[W-1:0];
    else                 result = pre[W-1:0];
  end
endmodule

module tensor_core_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3,
  parameter int LANES      = 1,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(DIM)
) (
  input  logic                                    tensor_core_clock,
  input  logic                                    tensor_core_reset_n,
  input  logic                                    tensor_core_register_file_write_enable,
  input  logic                                    should_start_tensor_core,
  input  logic [1:0]                              operation_select,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_input1,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_input2,
  output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_output,
  output logic                                    tensor_core_busy,
  output logic                                    tensor_core_done
);
  localparam int NELEM = DIM*DIM;
  localparam int IDX_W = $clog2(NELEM + LANES) + 1;
  localparam int RC_W  = $clog2(DIM);
  // Batch whose base index reaches this value holds the final element.
  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(NELEM - LANES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;

  logic [1:0]                              op_q;
  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0]                        idx;
  logic                                    accept, step, last;
  logic [LANES-1:0]                        l_act;
  logic [LANES-1:0][RC_W-1:0]              l_row, l_col;
  logic [LANES-1:0][DATA_WIDTH-1:0]        l_res;

  assign last   = idx >= LAST_BASE;
  assign accept = (state != RUN) && should_start_tensor_core &&
                  !tensor_core_register_file_write_enable;
  assign step   = (state == RUN) && !tensor_core_register_file_write_enable;

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: state_d = should_start_tensor_core ? RUN : IDLE;
      RUN:        if (last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (tensor_core_register_file_write_enable) state_d = IDLE;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tensor_core_lane #(
      .DATA_WIDTH(DATA_WIDTH), .DIM(DIM), .ACC_WIDTH(ACC_WIDTH),
      .IDX_W(IDX_W), .RC_W(RC_W)
    ) u_lane (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .c_old  (tensor_core_output),
      .elem   (idx + IDX_W'(l)),
      .active (l_act[l]),
      .row    (l_row[l]),
      .col    (l_col[l]),
      .result (l_res[l])
    );
  end

  always_ff @(posedge tensor_core_clock) begin
    if (!tensor_core_reset_n) begin
      state              <= IDLE;
      op_q               <= 2'b00;
      idx                <= '0;
      a_q                <= '0;
      b_q                <= '0;
      tensor_core_output <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q  <= tensor_core_input1;
        b_q  <= tensor_core_input2;
        op_q <= operation_select;
        idx  <= '0;
      end else if (step) begin
        idx <= idx + IDX_W'(LANES);
        for (int l = 0; l < LANES; l++)
          if (l_act[l]) tensor_core_output[l_row[l]][l_col[l]] <= l_res[l];
      end
    end
  end

  assign tensor_core_busy = (state == RUN);
  assign tensor_core_done = (state == DONE);
endmodule

// File: tb/tb_tensor_core_engine.sv
// Scoreboarded bench: a LANES=1 and a LANES=4 engine share stimulus; an
// integer-arithmetic matrix model predicts each completed result.

module tb_tensor_core_engine;
  localparam int DW = 8, DIM = 3;
  typedef logic [DIM-1:0][DIM-1:0][DW-1:0] mat_t;

  logic clk = 1'b0;
  logic rst_n, we, start;
  logic [1:0] op;
  mat_t a, b, c1, c4;
  logic busy1, done1, busy4, done4;

  int n_cmp = 0, n_bad = 0;
  mat_t exp1, exp4;
  mat_t q1[$], q4[$];

  always #5 clk = ~clk;

  tensor_core_engine #(.DATA_WIDTH(DW), .DIM(DIM), .LANES(1)) dut1 (
    .tensor_core_clock(clk), .tensor_core_reset_n(rst_n),
    .tensor_core_register_file_write_enable(we), .should_start_tensor_core(start),
    .operation_select(op), .tensor_core_input1(a), .tensor_core_input2(b),
    .tensor_core_output(c1), .tensor_core_busy(busy1), .tensor_core_done(done1));

  tensor_core_engine #(.DATA_WIDTH(DW), .DIM(DIM), .LANES(4)) dut4 (
    .tensor_core_clock(clk), .tensor_core_reset_n(rst_n),
    .tensor_core_register_file_write_enable(we), .should_start_tensor_core(start),
    .operation_select(op), .tensor_core_input1(a), .tensor_core_input2(b),
    .tensor_core_output(c4), .tensor_core_busy(busy4), .tensor_core_done(done4));

  function automatic int sx(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [DW-1:0] satv(int s);
    int hi, lo;
    hi = (1 << (DW-1)) - 1;
    lo = -(1 << (DW-1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return DW'(s);
  endfunction

  function automatic mat_t model(logic [1:0] o, mat_t x, mat_t y, mat_t cold);
    mat_t r;
    int s;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        s = 0;
        case (o)
          2'b00, 2'b11: begin
            for (int k = 0; k < DIM; k++) s += sx(x[i][k]) * sx(y[k][j]);
            if (o == 2'b11) s += sx(cold[i][j]);
          end
          2'b01:   s = sx(x[i][j]) + sx(y[i][j]);
          default: s = (sx(x[i][j]) < 0) ? 0 : sx(x[i][j]);
        endcase
        r[i][j] = satv(s);
      end
    return r;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int e = 0; e < DIM*DIM; e++) m[e/DIM][e%DIM] = DW'($urandom);
    return m;
  endfunction

  function automatic mat_t fill(int v);
    mat_t m;
    for (int e = 0; e < DIM*DIM; e++) m[e/DIM][e%DIM] = DW'(v);
    return m;
  endfunction

  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_mat(string name, mat_t act, mat_t expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done1_unexpected: got pulse expected none pending");
      end else chk_mat("dut1_result", c1, q1.pop_front());
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done4_unexpected: got pulse expected none pending");
      end else chk_mat("dut4_result", c4, q4.pop_front());
    end
  end

  task automatic run_op(input logic [1:0] o, input mat_t x, input mat_t y, input int restart_at);
    int d1 = -1, d4 = -1, n1 = 0, n4 = 0, bc1 = 0, bc4 = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp1 = model(o, x, y, exp1);
    exp4 = model(o, x, y, exp4);
    q1.push_back(exp1);
    q4.push_back(exp4);
    @(posedge clk); #1;
    for (int j = 0; j < 14; j++) begin
      a = rnd_mat(); b = rnd_mat(); op = 2'($urandom);
      start = (j + 1 == restart_at);
      if (busy1) bc1++;
      if (busy4) bc4++;
      if (done1) begin n1++; if (d1 < 0) d1 = j; end
      if (done4) begin n4++; if (d4 < 0) d4 = j; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy1_cycles", bc1, 9);
    chk("done1_edge", d1, 9);
    chk("done1_count", n1, 1);
    chk("busy4_cycles", bc4, 3);
    chk("done4_edge", d4, 3);
    chk("done4_count", n4, 1);
  endtask

  task automatic abort_run(input mat_t x, input mat_t y);
    mat_t full;
    int n1 = 0, n4 = 0;
    @(negedge clk);
    op = 2'b00; a = x; b = y; start = 1'b1;
    full = model(2'b00, x, y, exp1);
    for (int e = 0; e < 5; e++) exp1[e/DIM][e%DIM] = full[e/DIM][e%DIM];
    exp4 = model(2'b00, x, y, exp4);
    q4.push_back(exp4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      we = (j == 5);
      if (j == 5) chk("busy1_before_abort", int'(busy1), 1);
      if (j == 6) chk("busy1_after_abort", int'(busy1), 0);
      if (done1) n1++;
      if (done4) n4++;
      @(posedge clk); #1;
    end
    we = 1'b0;
    chk("abort_done1_count", n1, 0);
    chk("abort_done4_count", n4, 1);
    chk_mat("abort_partial", c1, exp1);
  endtask

  mat_t ident, b0, twob, relu_a;
  int b0v[9] = '{1, 2, 3, 4, 5, 6, 7, 8, -9};

  initial begin
    rst_n = 1'b0; we = 1'b0; start = 1'b0; op = 2'b00;
    a = rnd_mat(); b = rnd_mat();
    exp1 = '0; exp4 = '0;
    ident = '0;
    for (int i = 0; i < DIM; i++) ident[i][i] = 8'd1;
    for (int e = 0; e < 9; e++) begin
      b0[e/DIM][e%DIM]   = DW'(b0v[e]);
      twob[e/DIM][e%DIM] = DW'(2 * b0v[e]);
    end

    // Reset with garbage on the inputs, including a start request.
    @(negedge clk);
    start = 1'b1; op = 2'($urandom); a = rnd_mat(); b = rnd_mat();
    @(posedge clk); @(posedge clk); #1;
    chk_mat("reset_c1", c1, '0);
    chk_mat("reset_c4", c4, '0);
    chk("reset_busy1", int'(busy1), 0);
    chk("reset_done1", int'(done1), 0);
    chk("reset_busy4", int'(busy4), 0);
    start = 1'b0; rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_mat("idle_hold_c1", c1, '0);
    chk("idle_busy1", int'(busy1), 0);

    run_op(2'b00, ident, b0, 0);
    chk_mat("matmul_identity", c1, b0);
    run_op(2'b11, ident, b0, 0);
    chk_mat("accumulate_2b", c1, twob);
    run_op(2'b00, fill(127), fill(127), 0);
    chk_mat("matmul_sat_hi", c4, fill(127));
    run_op(2'b01, fill(-100), fill(-100), 0);
    chk_mat("add_sat_lo", c1, fill(-128));
    relu_a = rnd_mat();
    relu_a[0][0] = 8'hFF; relu_a[0][1] = 8'h00; relu_a[0][2] = 8'd5;
    run_op(2'b10, relu_a, rnd_mat(), 0);
    chk("relu_e0", sx(c1[0][0]), 0);
    chk("relu_e2", sx(c1[0][2]), 5);
    run_op(2'b00, ident, fill(100), 0);
    run_op(2'b11, ident, fill(100), 0);
    chk_mat("accumulate_clamp", c1, fill(127));

    run_op(2'($urandom), rnd_mat(), rnd_mat(), 2);
    abort_run(rnd_mat(), rnd_mat());

    // Abort and start on the same edge: abort wins.
    @(negedge clk);
    start = 1'b1; we = 1'b1; op = 2'($urandom); a = rnd_mat(); b = rnd_mat();
    @(posedge clk); #1;
    chk("we_start_busy1", int'(busy1), 0);
    chk("we_start_busy4", int'(busy4), 0);
    start = 1'b0; we = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk_mat("we_start_c1", c1, exp1);
    chk_mat("we_start_c4", c4, exp4);

    for (int n = 0; n < 10; n++) run_op(2'($urandom), rnd_mat(), rnd_mat(), 0);

    // Reset mid-run clears everything.
    @(negedge clk);
    start = 1'b1; op = 2'($urandom); a = rnd_mat(); b = rnd_mat();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_mat("midrun_reset_c1", c1, '0);
    chk_mat("midrun_reset_c4", c4, '0);
    chk("midrun_reset_busy1", int'(busy1), 0);
    chk("midrun_reset_busy4", int'(busy4), 0);
    exp1 = '0; exp4 = '0;
    run_op(2'b11, rnd_mat(), rnd_mat(), 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
